event_ts_scheduler: RTL and testbench

Shares one event timestamper between `N_REQ` requesters.
- Start side: allocates event IDs from a free pool and round-robin arbitrates start requests onto the timestamper start port.
- End side: checks tag ownership, then round-robin arbitrates end requests onto the timestamper end port.
- Result side: buffers results in a credit-managed FIFO, routes each result back to its owner, and frees the ID.
- Sits between requester logic (e.g. UDP RX/TX taps) and the timestamper.

---
 rtl/event_ts_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_event_ts_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_ts_scheduler.sv
// Shares one event timestamper between N_REQ requesters: ID pool + RR start
// arbitration, ownership-checked RR end arbitration, credit-managed result FIFO.

module event_ts_lane #(
  parameter int ID_W = 4,
  parameter int OW   = 1,
  parameter int LANE = 0
) (
  input  logic [(1<<ID_W)-1:0]         busy,
  input  logic [(1<<ID_W)-1:0][OW-1:0] owner,
  input  logic [ID_W-1:0]              tag,
  output logic                         good
);
  assign good = busy[tag] && (owner[tag] == OW'(LANE));
endmodule

module event_ts_scheduler #(
  parameter int N_REQ     = 2,
  parameter int ID_W      = 4,
  parameter int TS_W      = 64,
  parameter int OUT_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_start_valid,
  output logic [N_REQ-1:0]        req_start_ready,
  output logic [ID_W-1:0]         req_start_tag,
  input  logic [N_REQ-1:0]        req_end_valid,
  input  logic [N_REQ*ID_W-1:0]   req_end_tag,
  output logic [N_REQ-1:0]        req_end_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [ID_W-1:0]         rsp_tag,
  output logic [TS_W-1:0]         rsp_ts,
  output logic                    err_bad_end,
  output logic                    err_stray_rsp,
  output logic                    ts_start_valid,
  input  logic                    ts_start_ready,
  output logic [ID_W-1:0]         ts_start_id,
  output logic                    ts_end_valid,
  input  logic                    ts_end_ready,
  output logic [ID_W-1:0]         ts_end_id,
  input  logic                    ts_out_valid,
  output logic                    ts_out_ready,
  input  logic [ID_W-1:0]         ts_out_id,
  input  logic [TS_W-1:0]         ts_out_ts
);
  localparam int NID = 1 << ID_W;
  localparam int OW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW  = $clog2(OUT_DEPTH);

  typedef struct packed {
    logic [OW-1:0]   owner;
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] ts;
  } rsp_ent_t;

  logic [NID-1:0]              busy;
  logic [NID-1:0][OW-1:0]      owner;
  logic [OW-1:0]               st_ptr, en_ptr;
  rsp_ent_t                    fifo_mem [OUT_DEPTH];
  logic [PW:0]                 wr_ptr, rd_ptr, fifo_count;
  logic [PW:0]                 inflight;

  // First valid bit at or after ptr, cyclic; MSB of result = any valid.
  function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] v, input logic [OW-1:0] ptr);
    logic [OW:0] r;
    int idx;
    r = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (v[idx]) r = {1'b1, OW'(idx)};
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] rr_next(input logic [OW-1:0] g);
    if (int'(g) == N_REQ-1) return '0;
    return g + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [OW-1:0] g);
    logic [N_REQ-1:0] r;
    r = '0;
    r[g] = 1'b1;
    return r;
  endfunction

  // ---- start path
  logic [ID_W-1:0] free_id;
  logic            pool_empty;
  logic            st_any, st_fire;
  logic [OW-1:0]   st_g;

  always_comb begin
    free_id    = '0;
    pool_empty = 1'b1;
    for (int i = NID-1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_id    = ID_W'(i);
        pool_empty = 1'b0;
      end
    end
  end

  assign {st_any, st_g}  = rr_pick(req_start_valid, st_ptr);
  assign ts_start_valid  = rst_n && st_any && !pool_empty;
  assign ts_start_id     = free_id;
  assign req_start_tag   = free_id;
  assign st_fire         = ts_start_valid && ts_start_ready;
  assign req_start_ready = st_fire ? onehot(st_g) : '0;

  // ---- end path
  logic [N_REQ-1:0][ID_W-1:0] end_tag;
  logic [N_REQ-1:0]           end_good;
  logic                       en_any, en_fire, en_bad;
  logic [OW-1:0]              en_g;

  assign end_tag = req_end_tag;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    event_ts_lane #(.ID_W(ID_W), .OW(OW), .LANE(i)) u_lane (
      .busy (busy),
      .owner(owner),
      .tag  (end_tag[i]),
      .good (end_good[i])
    );
  end

  assign {en_any, en_g} = rr_pick(req_end_valid, en_ptr);
  assign ts_end_valid   = rst_n && en_any && end_good[en_g];
  assign ts_end_id      = end_tag[en_g];
  assign en_fire        = ts_end_valid && ts_end_ready;
  // Bad tags are consumed locally so a misbehaving requester cannot stall the port.
  assign en_bad         = rst_n && en_any && !end_good[en_g];
  assign req_end_ready  = (en_fire || en_bad) ? onehot(en_g) : '0;

  // ---- credit and result FIFO
  logic     push, pop, stray, fifo_empty;
  rsp_ent_t head, push_ent;

  assign fifo_count   = wr_ptr - rd_ptr;
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign ts_out_ready = rst_n && (({1'b0, fifo_count} + {1'b0, inflight}) < (PW+2)'(OUT_DEPTH));
  assign push         = ts_out_valid && (inflight != '0);
  assign stray        = ts_out_valid && (inflight == '0);

  assign push_ent.owner = owner[ts_out_id];
  assign push_ent.id    = ts_out_id;
  assign push_ent.ts    = ts_out_ts;

  assign head      = fifo_mem[rd_ptr[PW-1:0]];
  assign rsp_valid = (rst_n && !fifo_empty) ? onehot(head.owner) : '0;
  assign rsp_tag   = head.id;
  assign rsp_ts    = head.ts;
  assign pop       = rst_n && !fifo_empty && rsp_ready[head.owner];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= push_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= '0;
      owner         <= '0;
      st_ptr        <= '0;
      en_ptr        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      inflight      <= '0;
      err_bad_end   <= 1'b0;
      err_stray_rsp <= 1'b0;
    end else begin
      if (push) busy[ts_out_id] <= 1'b0;
      if (st_fire) begin
        busy[free_id]  <= 1'b1;
        owner[free_id] <= st_g;
        st_ptr         <= rr_next(st_g);
      end
      if (en_fire || en_bad) en_ptr <= rr_next(en_g);
      case ({en_fire, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      err_bad_end   <= en_bad;
      err_stray_rsp <= stray;
    end
  end
endmodule

// File: tb/tb_event_ts_scheduler.sv
// Directed bench for event_ts_scheduler with a small 2-cycle timestamper model.
module tb_event_ts_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_start_valid, req_start_ready, req_start_tag;
  logic [1:0]  req_end_valid, req_end_ready;
  logic [3:0]  req_end_tag;
  logic [1:0]  rsp_valid, rsp_ready, rsp_tag;
  logic [15:0] rsp_ts;
  logic        err_bad_end, err_stray_rsp;
  logic        ts_start_valid, ts_start_ready, ts_end_valid, ts_end_ready;
  logic        ts_out_valid, ts_out_ready;
  logic [1:0]  ts_start_id, ts_end_id, ts_out_id;
  logic [15:0] ts_out_ts;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  event_ts_scheduler #(.N_REQ(2), .ID_W(2), .TS_W(16), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_start_valid(req_start_valid), .req_start_ready(req_start_ready), .req_start_tag(req_start_tag),
    .req_end_valid(req_end_valid), .req_end_tag(req_end_tag), .req_end_ready(req_end_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_ts(rsp_ts),
    .err_bad_end(err_bad_end), .err_stray_rsp(err_stray_rsp),
    .ts_start_valid(ts_start_valid), .ts_start_ready(ts_start_ready), .ts_start_id(ts_start_id),
    .ts_end_valid(ts_end_valid), .ts_end_ready(ts_end_ready), .ts_end_id(ts_end_id),
    .ts_out_valid(ts_out_valid), .ts_out_ready(ts_out_ready), .ts_out_id(ts_out_id), .ts_out_ts(ts_out_ts)
  );

  // Timestamper model: free-running counter, result two cycles after end fire.
  logic [15:0] tcnt = 16'd0;
  logic [15:0] st_cnt [4];
  logic        p1_v = 1'b0, m_v = 1'b0;
  logic [1:0]  p1_id = 2'd0, m_id = 2'd0;
  logic [15:0] p1_ts = 16'd0, m_ts = 16'd0;
  int          end_fires = 0;
  logic        stray_v = 1'b0;
  logic [1:0]  stray_id = 2'd0;

  always @(posedge clk) begin
    tcnt <= tcnt + 16'd1;
    if (ts_start_valid && ts_start_ready) st_cnt[ts_start_id] <= tcnt;
    if (ts_end_valid && ts_end_ready) end_fires <= end_fires + 1;
    p1_v  <= ts_end_valid && ts_end_ready;
    p1_id <= ts_end_id;
    p1_ts <= tcnt - st_cnt[ts_end_id];
    m_v   <= p1_v;
    m_id  <= p1_id;
    m_ts  <= p1_ts;
  end

  assign ts_start_ready = 1'b1;
  assign ts_end_ready   = ts_out_ready;
  assign ts_out_valid   = m_v | stray_v;
  assign ts_out_id      = stray_v ? stray_id : m_id;
  assign ts_out_ts      = m_ts;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_start_valid = '0; req_end_valid = '0; req_end_tag = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; #1;
  endtask

  task automatic test_reset();
    req_start_valid = 2'b11; req_end_valid = '0; req_end_tag = '0; rsp_ready = 2'b11;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    total++; if (req_start_ready !== 2'b00) begin bad++; $display("FAIL rst_start_ready got=%b exp=00", req_start_ready); end
    total++; if (ts_start_valid !== 1'b0) begin bad++; $display("FAIL rst_ts_start_valid got=%b exp=0", ts_start_valid); end
    total++; if (ts_out_ready !== 1'b0) begin bad++; $display("FAIL rst_ts_out_ready got=%b exp=0", ts_out_ready); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=00", rsp_valid); end
    total++; if ({err_bad_end, err_stray_rsp} !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", {err_bad_end, err_stray_rsp}); end
    req_start_valid = '0; rst_n = 1'b1; #1;
    total++; if (ts_out_ready !== 1'b1) begin bad++; $display("FAIL rel_ts_out_ready got=%b exp=1", ts_out_ready); end
    total++; if (req_start_tag !== 2'd0) begin bad++; $display("FAIL rel_free_tag got=%0d exp=0", req_start_tag); end
  endtask

  task automatic test_rr_start();
    logic [1:0] exp_g [4];
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    req_start_valid = 2'b11; #1;
    for (int k = 0; k < 4; k++) begin
      total++; if (req_start_ready !== exp_g[k]) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_start_ready, exp_g[k]); end
      total++; if (req_start_tag !== 2'(k)) begin bad++; $display("FAIL rr_tag%0d got=%0d exp=%0d", k, req_start_tag, k); end
      step();
    end
    total++; if (req_start_ready !== 2'b00) begin bad++; $display("FAIL rr_full_ready got=%b exp=00", req_start_ready); end
    total++; if (ts_start_valid !== 1'b0) begin bad++; $display("FAIL rr_full_ts_valid got=%b exp=0", ts_start_valid); end
    req_start_valid = '0;
  endtask

  task automatic test_pool_exhaust();
    do_reset();
    req_start_valid = 2'b01; #1;
    for (int k = 0; k < 4; k++) step();
    total++; if (req_start_ready !== 2'b00) begin bad++; $display("FAIL ex_empty got=%b exp=00", req_start_ready); end
    req_end_valid = 2'b01; req_end_tag = 4'b0001; #1;
    total++; if ({ts_end_valid, ts_end_id} !== 3'b101) begin bad++; $display("FAIL ex_ts_end got=%b exp=101", {ts_end_valid, ts_end_id}); end
    total++; if (req_end_ready !== 2'b01) begin bad++; $display("FAIL ex_end_ready got=%b exp=01", req_end_ready); end
    step(); req_end_valid = '0; #1;
    for (int k = 1; k < 3; k++) begin
      total++; if (req_start_ready !== 2'b00) begin bad++; $display("FAIL ex_early%0d got=%b exp=00", k, req_start_ready); end
      step();
    end
    total++; if (req_start_ready !== 2'b01) begin bad++; $display("FAIL ex_realloc got=%b exp=01", req_start_ready); end
    total++; if (req_start_tag !== 2'd1) begin bad++; $display("FAIL ex_realloc_tag got=%0d exp=1", req_start_tag); end
    total++; if ({rsp_valid, rsp_tag} !== 4'b0101) begin bad++; $display("FAIL ex_rsp got=%b exp=0101", {rsp_valid, rsp_tag}); end
    req_start_valid = '0;
  endtask

  task automatic test_duration();
    logic [15:0] st;
    do_reset();
    for (int n = 0; n < 64 && tcnt[4:0] != 5'd10; n++) step();
    st = tcnt;
    req_start_valid = 2'b01; #1;
    total++; if ({req_start_ready, req_start_tag} !== 4'b0100) begin bad++; $display("FAIL dur_start got=%b exp=0100", {req_start_ready, req_start_tag}); end
    step(); req_start_valid = '0;
    for (int n = 0; n < 64 && tcnt != st + 16'd15; n++) step();
    req_end_valid = 2'b01; req_end_tag = 4'b0000; #1;
    total++; if (req_end_ready !== 2'b01) begin bad++; $display("FAIL dur_end got=%b exp=01", req_end_ready); end
    step(); req_end_valid = '0; #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL dur_early1 got=%b exp=00", rsp_valid); end
    step();
    total++; if (ts_out_valid !== 1'b1 || rsp_valid !== 2'b00) begin bad++; $display("FAIL dur_early2 got=%b%b exp=100", ts_out_valid, rsp_valid); end
    step();
    total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL dur_rsp_valid got=%b exp=01", rsp_valid); end
    total++; if (rsp_tag !== 2'd0) begin bad++; $display("FAIL dur_rsp_tag got=%0d exp=0", rsp_tag); end
    total++; if (rsp_ts !== 16'd15) begin bad++; $display("FAIL dur_rsp_ts got=%0d exp=15", rsp_ts); end
    rsp_ready = 2'b01; step(); rsp_ready = '0; #1;
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL dur_popped got=%b exp=00", rsp_valid); end
    total++; if (req_start_tag !== 2'd0) begin bad++; $display("FAIL dur_freed got=%0d exp=0", req_start_tag); end
  endtask

  task automatic test_bad_end();
    do_reset();
    req_start_valid = 2'b01; #1; step(); req_start_valid = '0;
    req_end_valid = 2'b10; req_end_tag = 4'b0000; #1;
    total++; if (req_end_ready !== 2'b10) begin bad++; $display("FAIL bad_ready got=%b exp=10", req_end_ready); end
    total++; if (ts_end_valid !== 1'b0) begin bad++; $display("FAIL bad_ts_end got=%b exp=0", ts_end_valid); end
    total++; if (err_bad_end !== 1'b0) begin bad++; $display("FAIL bad_err_early got=%b exp=0", err_bad_end); end
    step(); req_end_valid = '0; #1;
    total++; if (err_bad_end !== 1'b1) begin bad++; $display("FAIL bad_err_pulse got=%b exp=1", err_bad_end); end
    step();
    total++; if (err_bad_end !== 1'b0) begin bad++; $display("FAIL bad_err_clear got=%b exp=0", err_bad_end); end
    total++; if (req_start_tag !== 2'd1) begin bad++; $display("FAIL bad_still_busy got=%0d exp=1", req_start_tag); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL bad_no_rsp got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_backpressure();
    int f0, got, ended;
    logic [1:0]  gv [6];
    logic [1:0]  gt [6];
    logic [15:0] gs [6];
    logic [1:0]  ev [6];
    logic [1:0]  et [6];
    ev = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    et = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    f0 = end_fires;
    req_start_valid = 2'b01; #1;
    for (int k = 0; k < 4; k++) step();
    req_start_valid = '0;
    for (int k = 0; k < 4; k++) begin
      req_end_valid = 2'b01; req_end_tag = {2'b00, 2'(k)}; #1;
      total++; if (req_end_ready !== 2'b01) begin bad++; $display("FAIL bp_fire%0d got=%b exp=01", k, req_end_ready); end
      step();
    end
    req_end_valid = '0; #1;
    total++; if (ts_out_ready !== 1'b0) begin bad++; $display("FAIL bp_no_credit got=%b exp=0", ts_out_ready); end
    repeat (3) step();
    req_start_valid = 2'b10; #1;
    total++; if ({req_start_ready, req_start_tag} !== 4'b1000) begin bad++; $display("FAIL bp_restart0 got=%b exp=1000", {req_start_ready, req_start_tag}); end
    step();
    total++; if ({req_start_ready, req_start_tag} !== 4'b1001) begin bad++; $display("FAIL bp_restart1 got=%b exp=1001", {req_start_ready, req_start_tag}); end
    step(); req_start_valid = '0;
    req_end_valid = 2'b10; req_end_tag = 4'b0000; #1;
    for (int k = 0; k < 3; k++) begin
      total++; if ({ts_end_valid, req_end_ready} !== 3'b100) begin bad++; $display("FAIL bp_held%0d got=%b exp=100", k, {ts_end_valid, req_end_ready}); end
      step();
    end
    total++; if (end_fires - f0 !== 4) begin bad++; $display("FAIL bp_fire_count got=%0d exp=4", end_fires - f0); end
    rsp_ready = 2'b11; got = 0; ended = 0;
    for (int n = 0; n < 40 && got < 6; n++) begin
      #1;
      if (rsp_valid != 2'b00) begin
        gv[got] = rsp_valid; gt[got] = rsp_tag; gs[got] = rsp_ts; got++;
      end
      if (req_end_ready[1]) ended++;
      step();
      if (ended == 1) req_end_tag = 4'b0100;
      if (ended >= 2) req_end_valid = '0;
    end
    req_end_valid = '0; rsp_ready = '0;
    total++; if (got !== 6) begin bad++; $display("FAIL bp_rsp_count got=%0d exp=6", got); end
    for (int k = 0; k < got; k++) begin
      total++; if ({gv[k], gt[k]} !== {ev[k], et[k]}) begin bad++; $display("FAIL bp_order%0d got=%b/%0d exp=%b/%0d", k, gv[k], gt[k], ev[k], et[k]); end
      if (k < 4) begin
        total++; if (gs[k] !== 16'd4) begin bad++; $display("FAIL bp_ts%0d got=%0d exp=4", k, gs[k]); end
      end
    end
    total++; if (end_fires - f0 !== 6) begin bad++; $display("FAIL bp_total_fires got=%0d exp=6", end_fires - f0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req_start_valid = 2'b01; #1; step(); step(); req_start_valid = '0;
    req_end_valid = 2'b01; req_end_tag = 4'b0000; #1;
    total++; if (req_end_ready !== 2'b01) begin bad++; $display("FAIL ar_end0 got=%b exp=01", req_end_ready); end
    step(); req_end_tag = 4'b0001; #1;
    total++; if (req_end_ready !== 2'b01) begin bad++; $display("FAIL ar_end1 got=%b exp=01", req_end_ready); end
    step();
    req_start_valid = 2'b01; rst_n = 1'b0; #1;
    total++; if ({req_start_ready, ts_start_valid, req_end_ready, ts_end_valid} !== 6'b0) begin bad++;
      $display("FAIL ar_ready_low got=%b exp=000000", {req_start_ready, ts_start_valid, req_end_ready, ts_end_valid}); end
    total++; if ({ts_out_ready, rsp_valid, err_bad_end, err_stray_rsp} !== 5'b0) begin bad++;
      $display("FAIL ar_out_low got=%b exp=00000", {ts_out_ready, rsp_valid, err_bad_end, err_stray_rsp}); end
    total++; if (dut.busy !== 4'b0000) begin bad++; $display("FAIL ar_pool_free got=%b exp=0000", dut.busy); end
    repeat (4) @(posedge clk); #1;
    req_start_valid = '0; req_end_valid = '0; rst_n = 1'b1; #1;
    step();
    total++; if ({err_stray_rsp, rsp_valid} !== 3'b000) begin bad++; $display("FAIL ar_quiet got=%b exp=000", {err_stray_rsp, rsp_valid}); end
    stray_v = 1'b1; stray_id = 2'd2; step(); stray_v = 1'b0; #1;
    total++; if (err_stray_rsp !== 1'b1) begin bad++; $display("FAIL ar_stray_pulse got=%b exp=1", err_stray_rsp); end
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL ar_stray_no_rsp got=%b exp=00", rsp_valid); end
    step();
    total++; if ({err_stray_rsp, rsp_valid} !== 3'b000) begin bad++; $display("FAIL ar_stray_clear got=%b exp=000", {err_stray_rsp, rsp_valid}); end
  endtask

  initial begin
    test_reset();
    test_rr_start();
    test_pool_exhaust();
    test_duration();
    test_bad_end();
    test_backpressure();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
